// File: rtl/yuv_packer_pkg.sv
// Shared widths, output FSM state type and byte-order helper for the YUV422 USB packer.
package yuv_packer_pkg;

   localparam int YUV_IN_W     = 64;
   localparam int YUV_OUT_W    = 32;
   localparam int FIFO_ENTRY_W = YUV_IN_W + 1;

   typedef enum logic {
      ST_HI = 1'b0,
      ST_LO = 1'b1
   } out_state_e;

   // {Y,U,Y,V} -> {Y,V,Y,U}: exchange bytes 2 and 0.
   function automatic logic [YUV_OUT_W-1:0] uv_swap(input logic [YUV_OUT_W-1:0] w);
      return {w[31:24], w[7:0], w[15:8], w[23:16]};
   endfunction

endpackage

// File: rtl/yuv_sync_fifo.sv
// Single-clock FIFO with full/empty/level; pointers carry one extra wrap bit so full and empty differ.
module yuv_sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign level_o    = wr_ptr_q - rd_ptr_q;
   assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/yuv422_usb_packer.sv
// Buffers 64-bit 4-pixel YUV422 words and emits 32-bit pixel pairs under valid/ready, tracking lines and overflow.
// Define YUV_PACKER_UV_SWAP_EN to emit YVYU instead of YUYV.
module yuv422_usb_packer
   import yuv_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LINE_CNT_W = 16,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [YUV_IN_W-1:0]   yuv_i,
   input  logic                  yuv_valid_i,
   input  logic                  line_end_i,
   input  logic                  frame_start_i,
   output logic [YUV_OUT_W-1:0]  data_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic                  line_last_o,
   output logic [LINE_CNT_W-1:0] line_count_o,
   output logic                  overflow_o,
   output logic [LVL_W-1:0]      fifo_level_o
);

   logic [FIFO_ENTRY_W-1:0] fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [LVL_W-1:0]        fifo_level;
   logic                    fifo_pop;
   logic                    accept;
   logic                    drop;

   out_state_e              state_q;
   logic                    data_valid_q;
   logic [YUV_OUT_W-1:0]    data_q;
   logic [YUV_OUT_W-1:0]    lo_q;
   logic                    line_end_q;
   logic                    line_last_q;
   logic [LINE_CNT_W-1:0]   line_count_q, line_count_d;
   logic                    overflow_q, overflow_d;

   function automatic logic [YUV_OUT_W-1:0] out_fmt(input logic [YUV_OUT_W-1:0] w);
`ifdef YUV_PACKER_UV_SWAP_EN
      return uv_swap(w);
`else
      return w;
`endif
   endfunction

   assign accept = data_valid_q && data_ready_i;
   // Refill the holding register when it is idle or its low half is leaving this cycle.
   assign fifo_pop = !fifo_empty && (!data_valid_q || (accept && state_q == ST_LO));
   assign drop     = yuv_valid_i && fifo_full && !fifo_pop;

   yuv_sync_fifo #(
      .WIDTH (FIFO_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .push_i     (yuv_valid_i),
      .push_dat_i ({line_end_i, yuv_i}),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (fifo_level)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= ST_HI;
         data_valid_q <= 1'b0;
         data_q       <= '0;
         lo_q         <= '0;
         line_end_q   <= 1'b0;
         line_last_q  <= 1'b0;
      end else if (fifo_pop) begin
         state_q      <= ST_HI;
         data_valid_q <= 1'b1;
         data_q       <= out_fmt(fifo_head[YUV_IN_W-1:YUV_OUT_W]);
         lo_q         <= fifo_head[YUV_OUT_W-1:0];
         line_end_q   <= fifo_head[YUV_IN_W];
         line_last_q  <= 1'b0;
      end else if (accept) begin
         if (state_q == ST_HI) begin
            state_q     <= ST_LO;
            data_q      <= out_fmt(lo_q);
            line_last_q <= line_end_q;
         end else begin
            state_q      <= ST_HI;
            data_valid_q <= 1'b0;
            line_last_q  <= 1'b0;
         end
      end
   end

   // frame_start beats a line-last accept; a fresh overflow beats frame_start.
   always_comb begin
      line_count_d = line_count_q;
      if (frame_start_i)
         line_count_d = '0;
      else if (accept && line_last_q && line_count_q != '1)
         line_count_d = line_count_q + {{(LINE_CNT_W-1){1'b0}}, 1'b1};

      overflow_d = overflow_q;
      if (drop)
         overflow_d = 1'b1;
      else if (frame_start_i)
         overflow_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         line_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         line_count_q <= line_count_d;
         overflow_q   <= overflow_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = data_valid_q;
   assign line_last_o  = line_last_q;
   assign line_count_o = line_count_q;
   assign overflow_o   = overflow_q;
   assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_yuv422_usb_packer.sv
// Scoreboard bench for yuv422_usb_packer: directed words queue their expected halves, a monitor checks each accept.
module tb_yuv422_usb_packer;

   localparam int DEPTH = 16;
   localparam int LW    = 2;
   localparam int LVLW  = $clog2(DEPTH) + 1;

   logic            clk;
   logic            rst_n;
   logic [63:0]     yuv;
   logic            yuv_vld;
   logic            line_end;
   logic            frame_start;
   logic [31:0]     data;
   logic            data_vld;
   logic            ready;
   logic            line_last;
   logic [LW-1:0]   line_count;
   logic            overflow;
   logic [LVLW-1:0] level;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   yuv422_usb_packer #(.FIFO_DEPTH(DEPTH), .LINE_CNT_W(LW)) dut (
      .clk_i         (clk),
      .reset_i       (rst_n),
      .yuv_i         (yuv),
      .yuv_valid_i   (yuv_vld),
      .line_end_i    (line_end),
      .frame_start_i (frame_start),
      .data_o        (data),
      .data_valid_o  (data_vld),
      .data_ready_i  (ready),
      .line_last_o   (line_last),
      .line_count_o  (line_count),
      .overflow_o    (overflow),
      .fifo_level_o  (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef YUV_PACKER_UV_SWAP_EN
      return {w[31:24], w[7:0], w[15:8], w[23:16]};
`else
      return w;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [63:0] w, input logic le);
      q.push_back('{fmt(w[63:32]), 1'b0});
      q.push_back('{fmt(w[31:0]), le});
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w, input logic le);
      yuv      = w;
      line_end = le;
      yuv_vld  = 1'b1;
      tick();
      yuv_vld  = 1'b0;
      line_end = 1'b0;
   endtask

   // Sample just before each rising edge, where a valid&ready pair is an accept.
   always @(negedge clk) begin
      #4;
      if (rst_n && data_vld && ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got %0h, no word expected", data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", {32'd0, data}, {32'd0, e.d});
            chk("out_last", {63'd0, line_last}, {63'd0, e.l});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [63:0] w;
      logic [31:0] uv_exp;

      rst_n = 1'b0; yuv = '0; yuv_vld = 1'b0; line_end = 1'b0;
      frame_start = 1'b0; ready = 1'b0;
      #3;
      chk("rst_valid", {63'd0, data_vld}, 64'd0);
      chk("rst_data", {32'd0, data}, 64'd0);
      chk("rst_last", {63'd0, line_last}, 64'd0);
      chk("rst_count", {62'd0, line_count}, 64'd0);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
      chk("rst_level", {59'd0, level}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single word with line end, ready held high
      ready = 1'b1;
      expect_word(64'h11223344_55667788, 1'b1);
      send(64'h11223344_55667788, 1'b1);
      chk("lat_e0_valid", {63'd0, data_vld}, 64'd0);
      chk("lat_e0_level", {59'd0, level}, 64'd1);
      tick();
      chk("lat_e1_valid", {63'd0, data_vld}, 64'd1);
      chk("lat_e1_data", {32'd0, data}, {32'd0, fmt(32'h11223344)});
      chk("lat_e1_last", {63'd0, line_last}, 64'd0);
      tick();
      chk("lo_data", {32'd0, data}, {32'd0, fmt(32'h55667788)});
      chk("lo_last", {63'd0, line_last}, 64'd1);
      tick();
      chk("single_count", {62'd0, line_count}, 64'd1);
      chk("single_idle", {63'd0, data_vld}, 64'd0);

      // Backpressure: three words queued while ready is low
      ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         w = {8'(i), 24'h0A0B0C, 8'(i), 24'h0D0E0F};
         expect_word(w, 1'b0);
         send(w, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_data", {32'd0, data}, {32'd0, fmt(32'h010A0B0C)});
         chk("bp_hold_valid", {63'd0, data_vld}, 64'd1);
         tick();
      end
      chk("bp_level", {59'd0, level}, 64'd2);
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("bp_no_gap", {63'd0, data_vld}, 64'd1);
         tick();
      end
      chk("bp_drained", {63'd0, data_vld}, 64'd0);

      // Frame with four lines; the count saturates at all-ones
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_count_clr", {62'd0, line_count}, 64'd0);
      for (int l = 1; l <= 4; l++) begin
         for (int k = 0; k < 4; k++) begin
            w = {16'(l), 16'(k), 16'hABCD, 16'(l * 4 + k)};
            expect_word(w, k == 3);
            send(w, k == 3);
            tick();
         end
         tick();
         tick();
         chk("line_count", {62'd0, line_count}, (l < 3) ? 64'(l) : 64'd3);
      end

      // frame_start on the same cycle as a line-last accept
      ready = 1'b0;
      expect_word(64'hCAFE0001_CAFE0002, 1'b1);
      send(64'hCAFE0001_CAFE0002, 1'b1);
      tick();
      chk("coin_hi_last", {63'd0, line_last}, 64'd0);
      ready = 1'b1;
      tick();
      chk("coin_lo_last", {63'd0, line_last}, 64'd1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("coin_count", {62'd0, line_count}, 64'd0);
      tick();

      // Overflow: DEPTH+2 words with ready low; the last one is dropped
      ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         w = {32'hC0DE0000 | 32'(i), 32'hBEEF0000 | 32'(i)};
         if (i < DEPTH + 1) expect_word(w, 1'b0);
         send(w, 1'b0);
      end
      chk("ovf_flag", {63'd0, overflow}, 64'd1);
      chk("ovf_level", {59'd0, level}, 64'(DEPTH));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("ovf_clr", {63'd0, overflow}, 64'd0);
      chk("ovf_keep_level", {59'd0, level}, 64'(DEPTH));
      ready = 1'b1;
      tick();
      // The next edge pops the full FIFO while this word is pushed
      expect_word(64'h5A5A0001_A5A50001, 1'b0);
      send(64'h5A5A0001_A5A50001, 1'b0);
      chk("full_pushpop_ovf", {63'd0, overflow}, 64'd0);
      chk("full_pushpop_level", {59'd0, level}, 64'(DEPTH));
      repeat (40) tick();
      chk("drain_empty", 64'(q.size()), 64'd0);

      // Async reset with words queued, then nominal latency after release
      ready = 1'b0;
      for (int i = 0; i < 5; i++) send({32'h77770000 | 32'(i), 32'h88880000}, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, data_vld}, 64'd0);
      chk("arst_data", {32'd0, data}, 64'd0);
      chk("arst_level", {59'd0, level}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      ready = 1'b1;
      expect_word(64'h12345678_9ABCDEF0, 1'b0);
      send(64'h12345678_9ABCDEF0, 1'b0);
      chk("post_rst_e0", {63'd0, data_vld}, 64'd0);
      tick();
      chk("post_rst_e1", {63'd0, data_vld}, 64'd1);
      chk("post_rst_data", {32'd0, data}, {32'd0, fmt(32'h12345678)});
      tick();
      tick();

      // UV byte order
`ifdef YUV_PACKER_UV_SWAP_EN
      uv_exp = 32'hA0D3C2B1;
`else
      uv_exp = 32'hA0B1C2D3;
`endif
      expect_word(64'hA0B1C2D3_00000000, 1'b0);
      send(64'hA0B1C2D3_00000000, 1'b0);
      tick();
      chk("uv_order", {32'd0, data}, {32'd0, uv_exp});
      repeat (4) tick();
      chk("final_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/yuv422_usb_packer.md
Name: yuv422_usb_packer

Overview:
- Consumes the 64-bit, 4-pixel YUV422 words produced by the RGB-to-YUV stage (no backpressure upstream).
- Buffers them in a small synchronous FIFO and emits 32-bit, 2-pixel words toward the USB3 parallel (FX3 GPIF) output stage under a valid/ready handshake.
- Tracks line boundaries and completed lines per frame, and flags data loss.

Parameters:
- FIFO_DEPTH, 16, 64-bit entries buffered; power of two, minimum 4.
- LINE_CNT_W, 16, width of line_count_o.

Ports:
- clk_i  in  1  single clock; all logic on rising edge (upstream updates on falling edge, so inputs are stable at rising edge).
- reset_i  in  1  asynchronous, active-low reset.
- yuv_i  in  64  {Y0,U0,Y1,V0,Y2,U2,Y3,V2}, MSB byte first.
- yuv_valid_i  in  1  yuv_i valid this cycle.
- line_end_i  in  1  qualifies yuv_valid_i; marks last word of a line.
- frame_start_i  in  1  one-cycle pulse before the first word of a frame.
- data_o  out  32  output pixel pair.
- data_valid_o  out  1  data_o valid.
- data_ready_i  in  1  downstream accepts when valid&ready.
- line_last_o  out  1  data_o is the final 32-bit word of a line.
- line_count_o  out  LINE_CNT_W  lines fully delivered in current frame.
- overflow_o  out  1  sticky; a word was dropped due to full FIFO.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, phase=0, all outputs 0.
- Capture: on rising edge with yuv_valid_i=1 and FIFO not full -> push {line_end_i, yuv_i}.
- FIFO full + yuv_valid_i=1 -> word dropped, no pointer change, overflow_o<=1.
- Push and pop in the same cycle while full -> the pop frees a slot and the push is accepted (no overflow).
- Output FSM, two states:
  - HI: present yuv[63:32], line_last_o=0.
  - LO: present yuv[31:0], line_last_o=stored line_end.
  - HI->LO on accept.
  - LO->HI on accept; the entry is popped at this point.
- data_valid_o=1 whenever the output holding register is loaded. The register is loaded from FIFO head when empty, or on the LO accept if FIFO non-empty.
- Latency: word captured at edge E into empty FIFO with idle output -> data_valid_o high after edge E+1 (HI half).
- data_o, line_last_o and data_valid_o are held stable while data_valid_o=1 and data_ready_i=0.
- Sustained throughput: one 32-bit word per cycle with data_ready_i=1. Upstream can therefore average at most one 64-bit word per 2 cycles without overflow.
- line_count_o increments on accept of a word with line_last_o=1. It saturates at all-ones (no wrap).
- frame_start_i: clears line_count_o and overflow_o; does not flush FIFO or output.
- frame_start_i coincident with a line_last accept -> count becomes 0 (frame_start wins).
- frame_start_i coincident with an overflow event -> overflow_o=1 (the new event wins).
- fifo_level_o counts only FIFO entries, not the entry held in the output register.

Optional Feature:
- Macro: YUV_PACKER_UV_SWAP_EN.
- Defined: within each 32-bit output word, bytes 2 and 0 (U and V) are exchanged, giving {Y,V,Y,U} order for hosts expecting YVYU.
- Undefined: order passes through unchanged ({Y,U,Y,V}, YUYV).
- line_last_o and the handshake are unaffected in either case.

Decomposition:
- Package yuv_packer_pkg:
  - constants YUV_IN_W=64, YUV_OUT_W=32.
  - FSM state enum {ST_HI, ST_LO}.
  - FIFO entry width (65).
- Sub-module yuv_sync_fifo: parameterised width and depth, with full/empty/level. Pointers are one bit wider than the address to distinguish full from empty.
- The top level holds the output FSM, counters and flags.

Test Plan:
- Single word: reset, push 0x11223344_55667788 with line_end=1, ready=1 -> data_o=0x11223344, line_last=0 at edge E+1; then 0x55667788 with line_last=1; line_count_o=1.
- Backpressure: ready=0 for 5 cycles with 3 words queued -> data_o is stable at the first HI half and fifo_level_o=2. Release ready -> 6 outputs in order with no gaps.
- Overflow: ready=0, push FIFO_DEPTH+2 words (in excess of FIFO_DEPTH + 1 held in the output register) -> overflow_o=1, fifo_level_o=16, and the last word is dropped. frame_start_i pulse -> overflow_o=0 with FIFO contents retained.
- Frame/line: 3 lines of 4 words each, frame_start_i before line 1 -> line_count_o goes 1,2,3. frame_start_i on the same cycle as the 3rd line_last accept -> count=0.
- Async reset mid-stream: assert reset_i low with 5 words queued -> all outputs 0 immediately with no clock; after release, the first new word appears with nominal latency.
- UV swap (macro defined): input 0xA0B1C2D3_00000000 -> data_o=0xA0D3C2B1.
